// File: rtl/onewire_half_duplex.sv
// -----------------------------------------------------------------------------
// onewire_half_duplex
//   Half-duplex single-wire UART-framed engine (1 start, 8 data LSB first,
//   1 stop) sitting directly upstream of a bidirectional pad cell with a
//   pull-up. The engine either transmits (drives the pad) or receives
//   (listens on pad DOUT), never both at once.
//
// Parameters
//   CLKS_PER_BIT    clk cycles per bit, even and >= 4
//   TURNAROUND_BITS bit-times after our own stop bit during which the line is
//                   released and RX edges are ignored (0 = no guard)
//
// Ports
//   clk, rst          system clock (rising edge), async active-high reset
//   tx_data/valid     TX byte and request; tx_ready completes the handshake
//   tx_ready          high only in IDLE with no RX start edge this cycle
//   rx_data           last received byte, held between frames
//   rx_valid          one-cycle pulse, good frame
//   rx_frame_err      one-cycle pulse, stop bit sampled 0
//   busy              engine not in IDLE
//   pad_din, pad_oe   to pad cell (pad_oe active low: 0 = pad drives)
//   pad_dout          line level from pad cell
//
// Configuration
//   ONEWIRE_RX_MAJORITY_EN  when defined, each RX sample is a 2-of-3 majority
//                           over the synchronized line at mid-1, mid, mid+1
//                           and the decision is taken at mid+1.
//
// Handshake: a TX byte is accepted on the rising clk edge where
// tx_valid && tx_ready; tx_data must be stable in that cycle. rx_valid and
// rx_frame_err are single-cycle strobes with no back-pressure.
// -----------------------------------------------------------------------------
module onewire_half_duplex #(
   parameter int CLKS_PER_BIT    = 16,
   parameter int TURNAROUND_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err,
   output logic       busy,
   output logic       pad_din,
   output logic       pad_oe,
   input  logic       pad_dout
);

   localparam int GUARD_CYCLES = CLKS_PER_BIT * ((TURNAROUND_BITS > 0) ? TURNAROUND_BITS : 1);
   localparam int CW           = $clog2(GUARD_CYCLES);

   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
`ifdef ONEWIRE_RX_MAJORITY_EN
   // One extra cycle so the decision lands at mid+1 with all three taps valid.
   localparam logic [CW-1:0] START_LAST = CW'(CLKS_PER_BIT / 2);
`else
   localparam logic [CW-1:0] START_LAST = CW'(CLKS_PER_BIT / 2 - 1);
`endif

   typedef enum logic [3:0] {
      IDLE,
      TX_START,
      TX_DATA,
      TX_STOP,
      TX_GUARD,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          rx_err_q, rx_err_d;
   logic          pad_oe_q, pad_oe_d;
   logic          pad_din_q, pad_din_d;

   // Synchronizer: meta_q -> sync_q; prev_q is the previous synchronized sample.
   logic          meta_q, sync_q, prev_q;
   logic          fall, cnt_zero, rx_bit;

   assign fall     = prev_q & ~sync_q;
   assign cnt_zero = (cnt_q == '0);

`ifdef ONEWIRE_RX_MAJORITY_EN
   logic prev2_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev2_q <= 1'b1;
      else     prev2_q <= prev_q;
   end
   assign rx_bit = (sync_q & prev_q) | (sync_q & prev2_q) | (prev_q & prev2_q);
`else
   assign rx_bit = sync_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q     <= 1'b1;
         sync_q     <= 1'b1;
         prev_q     <= 1'b1;
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_err_q   <= 1'b0;
         pad_oe_q   <= 1'b1;
         pad_din_q  <= 1'b1;
      end else begin
         meta_q     <= pad_dout;
         sync_q     <= meta_q;
         prev_q     <= sync_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_err_q   <= rx_err_d;
         pad_oe_q   <= pad_oe_d;
         pad_din_q  <= pad_din_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_err_d   = 1'b0;
      pad_oe_d   = pad_oe_q;
      pad_din_d  = pad_din_q;

      case (state_q)
         IDLE: begin
            pad_oe_d  = 1'b1;
            pad_din_d = 1'b1;
            // An RX start edge wins; a pending TX request simply waits.
            if (fall) begin
               state_d = RX_START;
               cnt_d   = START_LAST;
            end else if (tx_valid) begin
               state_d    = TX_START;
               tx_shift_d = tx_data;
               pad_oe_d   = 1'b0;
               pad_din_d  = 1'b0;
               cnt_d      = BIT_LAST;
            end
         end

         TX_START: begin
            if (cnt_zero) begin
               state_d   = TX_DATA;
               pad_din_d = tx_shift_q[0];
               bit_d     = '0;
               cnt_d     = BIT_LAST;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         TX_DATA: begin
            if (cnt_zero) begin
               cnt_d = BIT_LAST;
               if (bit_q == 4'd7) begin
                  state_d   = TX_STOP;
                  pad_din_d = 1'b1;
               end else begin
                  bit_d      = bit_q + 4'd1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  pad_din_d  = tx_shift_q[1];
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         TX_STOP: begin
            if (cnt_zero) begin
               pad_oe_d  = 1'b1;
               pad_din_d = 1'b1;
               if (TURNAROUND_BITS == 0) begin
                  state_d = IDLE;
               end else begin
                  state_d = TX_GUARD;
                  cnt_d   = GUARD_LAST;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         TX_GUARD: begin
            if (cnt_zero) state_d = IDLE;
            else          cnt_d   = cnt_q - CNT_ONE;
         end

         RX_START: begin
            if (cnt_zero) begin
               if (rx_bit) begin
                  state_d = IDLE;       // false start, line already back high
               end else begin
                  state_d = RX_DATA;
                  bit_d   = '0;
                  cnt_d   = BIT_LAST;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         RX_DATA: begin
            if (cnt_zero) begin
               rx_shift_d = {rx_bit, rx_shift_q[7:1]};
               cnt_d      = BIT_LAST;
               if (bit_q == 4'd7) state_d = RX_STOP;
               else               bit_d   = bit_q + 4'd1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         RX_STOP: begin
            if (cnt_zero) begin
               rx_data_d = rx_shift_q;
               if (rx_bit) begin
                  rx_valid_d = 1'b1;
                  state_d    = IDLE;
               end else begin
                  rx_err_d = 1'b1;
                  state_d  = RX_WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         RX_WAIT_HIGH: begin
            if (sync_q) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign tx_ready     = (state_q == IDLE) & ~fall & ~rst;
   assign busy         = (state_q != IDLE);
   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign rx_frame_err = rx_err_q;
   assign pad_oe       = pad_oe_q;
   assign pad_din      = pad_din_q;

endmodule

// File: tb/tb_onewire_half_duplex.sv
// -----------------------------------------------------------------------------
// tb_onewire_half_duplex
//   Directed bench for onewire_half_duplex at CLKS_PER_BIT=8, TURNAROUND_BITS=1.
//   The pad is modelled as: pad drives pad_din when pad_oe=0, otherwise the
//   line follows ext_line (bench drive, idle high through the pull-up).
// -----------------------------------------------------------------------------
module tb_onewire_half_duplex;

   localparam int CPB = 8;
`ifdef ONEWIRE_RX_MAJORITY_EN
   localparam int MAJ = 1;
`else
   localparam int MAJ = 0;
`endif
   // Cycles from the bench driving the start edge to the observed strobe.
   localparam int RX_LAT = 79 + MAJ;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       busy;
   logic       pad_din;
   logic       pad_oe;
   logic       pad_dout;
   logic       ext_line;

   assign pad_dout = pad_oe ? ext_line : pad_din;

   onewire_half_duplex #(
      .CLKS_PER_BIT   (CPB),
      .TURNAROUND_BITS(1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_frame_err(rx_frame_err),
      .busy        (busy),
      .pad_din     (pad_din),
      .pad_oe      (pad_oe),
      .pad_dout    (pad_dout)
   );

   // ---------------- clock / reset block ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   int n_valid = 0;
   int n_err = 0;
   int last_valid_cyc = 0;
   int last_err_cyc = 0;

   always @(negedge clk) begin
      if (rx_valid) begin
         n_valid++;
         last_valid_cyc = cyc;
      end
      if (rx_frame_err) begin
         n_err++;
         last_err_cyc = cyc;
      end
      if (rx_valid || rx_frame_err) begin
         check("rx_strobe_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) check("rx_data_sb", rx_data, exp_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   int t_start = 0;

   // Call just after a rising edge; returns one rising edge + #1 after the
   // stop bit has been on the line for CPB cycles. Line is left at 'stop'.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      t_start  = cyc;
      ext_line = 1'b0;
      repeat (CPB) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         ext_line = b[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      ext_line = stop;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic tx_handshake(input logic [7:0] d);
      @(posedge clk);
      #1;
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      check("tx_ready_before_hs", tx_ready, 1);
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   int         v0, e0, nb, hs, tmo;
   logic [9:0] frame;

   initial begin
      rst      = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      ext_line = 1'b1;
      #1 rst = 1'b1;
      #1;
      check("rst_pad_oe", pad_oe, 1);
      check("rst_pad_din", pad_din, 1);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_err", rx_frame_err, 0);
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;

      // ---- T1: reset in the middle of a TX frame ----
      tx_handshake(8'h00);
      repeat (20) @(posedge clk);
      #3;
      check("t1_mid_oe", pad_oe, 0);
      check("t1_mid_din", pad_din, 0);
      rst = 1'b1;
      #1;
      check("t1_async_oe", pad_oe, 1);
      check("t1_async_din", pad_din, 1);
      check("t1_rst_ready", tx_ready, 0);
      check("t1_rst_busy", busy, 0);
      @(posedge clk);
      #3;
      check("t1_rst_ready_hold", tx_ready, 0);
      v0 = n_valid;
      e0 = n_err;
      rst = 1'b0;
      @(negedge clk);
      check("t1_post_ready", tx_ready, 1);
      check("t1_post_busy", busy, 0);
      repeat (20) @(negedge clk);
      check("t1_no_rx_valid", n_valid, v0);
      check("t1_no_rx_err", n_err, e0);

      // ---- T2: transmit 0xA5 ----
      v0 = n_valid;
      e0 = n_err;
      tx_handshake(8'hA5);
      frame = {1'b1, 8'hA5, 1'b0};
      for (int j = 0; j < 89; j++) begin
         @(negedge clk);
         if (j < 80) begin
            check("t2_oe", pad_oe, 0);
            check("t2_din", pad_din, frame[j/8]);
         end else if (j < 88) begin
            check("t2_guard_oe", pad_oe, 1);
            check("t2_guard_busy", busy, 1);
            check("t2_guard_ready", tx_ready, 0);
         end else begin
            check("t2_ready_back", tx_ready, 1);
            check("t2_idle_busy", busy, 0);
         end
      end
      check("t2_echo_no_valid", n_valid, v0);
      check("t2_echo_no_err", n_err, e0);

      // ---- T3: receive 0x3C ----
      v0 = n_valid;
      e0 = n_err;
      @(posedge clk);
      #1;
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      repeat (4) @(negedge clk);
      check("t3_valid_count", n_valid - v0, 1);
      check("t3_err_count", n_err - e0, 0);
      check("t3_rx_data", rx_data, 8'h3C);
      check("t3_latency", last_valid_cyc - t_start, RX_LAT);
      repeat (20) @(negedge clk);
      check("t3_rx_data_hold", rx_data, 8'h3C);

      // ---- T4: 2-cycle glitch on the idle line ----
      v0 = n_valid;
      e0 = n_err;
      @(posedge clk);
      #1 ext_line = 1'b0;
      repeat (2) @(posedge clk);
      #1 ext_line = 1'b1;
      nb = 0;
      repeat (12) begin
         @(negedge clk);
         if (busy) nb++;
      end
      check("t4_busy_cycles", nb, 4 + MAJ);
      check("t4_busy_end", busy, 0);
      check("t4_ready_end", tx_ready, 1);
      check("t4_no_valid", n_valid, v0);
      check("t4_no_err", n_err, e0);

      // ---- T5: 0x81 with stop bit 0, line held low ----
      v0 = n_valid;
      e0 = n_err;
      @(posedge clk);
      #1;
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b0);
      repeat (40) @(posedge clk);
      #1;
      check("t5_busy_low", busy, 1);
      check("t5_err_count", n_err - e0, 1);
      check("t5_valid_count", n_valid, v0);
      check("t5_rx_data", rx_data, 8'h81);
      check("t5_err_latency", last_err_cyc - t_start, RX_LAT);
      ext_line = 1'b1;
      repeat (2) @(negedge clk);
      check("t5_busy_sync", busy, 1);
      repeat (2) @(negedge clk);
      check("t5_busy_released", busy, 0);
      check("t5_ready_released", tx_ready, 1);
      check("t5_err_once", n_err - e0, 1);

      // ---- T6: TX request colliding with an RX start edge ----
      v0 = n_valid;
      e0 = n_err;
      hs = -1;
      @(posedge clk);
      #1;
      exp_q.push_back(8'h55);
      fork
         send_frame(8'h55, 1'b1);
         begin
            repeat (2) @(posedge clk);
            #1;
            tx_data  = 8'h12;
            tx_valid = 1'b1;
            @(negedge clk);
            check("t6_ready_on_edge", tx_ready, 0);
            for (int k = 0; k < 200; k++) begin
               @(negedge clk);
               if (tx_ready) begin
                  hs = cyc - t_start;
                  break;
               end
               check("t6_oe_held", pad_oe, 1);
            end
            @(posedge clk);
            #1 tx_valid = 1'b0;
         end
      join
      check("t6_hs_cycle", hs, RX_LAT);
      check("t6_rx_valid_count", n_valid - v0, 1);
      check("t6_rx_valid_cycle", last_valid_cyc - t_start, RX_LAT);
      check("t6_rx_data", rx_data, 8'h55);
      @(negedge clk);
      check("t6_tx_started", pad_oe, 0);
      tmo = 1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (pad_oe) begin
            tmo = 0;
            break;
         end
      end
      check("t6_tx_end_timeout", tmo, 0);
      // Low pulse on the released line during the guard window.
      @(posedge clk);
      #1 ext_line = 1'b0;
      repeat (2) @(posedge clk);
      #1 ext_line = 1'b1;
      tmo = 1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (tx_ready) begin
            tmo = 0;
            break;
         end
      end
      check("t6_guard_ready_timeout", tmo, 0);
      nb = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy) nb++;
      end
      check("t6_guard_no_busy", nb, 0);
      check("t6_guard_no_valid", n_valid - v0, 1);
      check("t6_guard_no_err", n_err, e0);

      check("exp_q_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
